dstack_spill_ctrl: RTL and testbench

// Owns the data-stack register buffer behind dstack_control. Applies each

---
 rtl/dstack_spill_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_dstack_spill_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dstack_spill_ctrl.sv
// -----------------------------------------------------------------------------
// dstack_spill_ctrl
//
// Register buffer for the data stack. Entry 0 is the top of stack. Each
// accepted instruction step applies its movement (hold / push1 / pop1 / pop2)
// and writes next_top into entry 0 on the same clock edge. When too many
// entries are resident, the bottom one is spilled to a backing memory. When
// too few are resident, an entry is filled back from that memory. High and
// low water marks keep the buffer from thrashing. A step that cannot complete
// without memory traffic is held off with stall.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   step_valid            a step is presented this cycle
//   movement[1:0]         00 hold, 01 push1, 10 pop1, 11 pop2
//   next_top              top-of-stack value after the movement
//   stall                 step not accepted this cycle (combinational)
//   top/second/third      entries 0, 1 and 2
//   depth                 total stack depth (spilled + resident)
//   mem_req/mem_we        memory request; we = 1 spill write, 0 fill read
//   mem_addr/mem_wdata    registered request address / spill data
//   mem_ack/mem_rdata     request completion and fill data
//   err_overflow          sticky: an entry was dropped at full depth
// -----------------------------------------------------------------------------
module dstack_spill_ctrl #(
  parameter int WORD_WIDTH  = 32,
  parameter int LOCAL_DEPTH = 8,
  parameter int ADDR_WIDTH  = 10,
  parameter int HIGH_WATER  = 7,
  parameter int LOW_WATER   = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    step_valid,
  input  logic [1:0]              movement,
  input  logic [WORD_WIDTH-1:0]   next_top,
  output logic                    stall,
  output logic [WORD_WIDTH-1:0]   top,
  output logic [WORD_WIDTH-1:0]   second,
  output logic [WORD_WIDTH-1:0]   third,
  output logic [ADDR_WIDTH+4:0]   depth,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [WORD_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ack,
  input  logic [WORD_WIDTH-1:0]   mem_rdata,
  output logic                    err_overflow
);

  localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;
  localparam int RW        = $clog2(LOCAL_DEPTH + 1);   // resident count width
  localparam int IW        = $clog2(LOCAL_DEPTH);       // entry index width
  localparam int PW        = ADDR_WIDTH + 1;            // spill_ptr reaches MEM_DEPTH
  localparam int DW        = ADDR_WIDTH + 5;

  localparam logic [RW-1:0] RES_FULL = RW'(LOCAL_DEPTH);
  localparam logic [RW-1:0] RES_HIGH = RW'(HIGH_WATER);
  localparam logic [RW-1:0] RES_LOW  = RW'(LOW_WATER);
  localparam logic [PW-1:0] PTR_FULL = PW'(MEM_DEPTH);

  localparam logic [1:0] MV_HOLD = 2'b00;
  localparam logic [1:0] MV_PUSH = 2'b01;
  localparam logic [1:0] MV_POP1 = 2'b10;
  localparam logic [1:0] MV_POP2 = 2'b11;

  typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;

  state_t                  state_q, state_d;
  logic [WORD_WIDTH-1:0]   entry_q [LOCAL_DEPTH];
  logic [RW-1:0]           resident_q;
  logic [PW-1:0]           spill_ptr_q;

  logic          is_push, is_pop;
  logic [RW-1:0] npops, pop_limit;
  logic          ptr_full, ptr_empty;
  logic          push_hz, pop_hz, accept, ack_done;
  logic          start_spill, start_fill;
  logic [IW-1:0] bot_idx, fill_idx;

  assign is_push   = (movement == MV_PUSH);
  assign is_pop    = movement[1];
  assign npops     = movement[0] ? RW'(2) : RW'(1);
  // A pop of n needs n+3 live entries so that top/second/third stay valid.
  assign pop_limit = movement[0] ? RW'(5) : RW'(4);
  assign ptr_full  = (spill_ptr_q == PTR_FULL);
  assign ptr_empty = (spill_ptr_q == '0);

  assign push_hz = step_valid && is_push && (resident_q == RES_FULL) && !ptr_full;
  assign pop_hz  = step_valid && is_pop && !ptr_empty && (resident_q < pop_limit);

  assign stall    = step_valid && ((state_q != IDLE) || push_hz || pop_hz);
  assign accept   = step_valid && !stall;
  assign ack_done = mem_req && mem_ack;

  // Bottom resident entry (spill source) and first free slot (fill target).
  assign bot_idx  = IW'(resident_q - RW'(1));
  assign fill_idx = IW'(resident_q);

  assign top    = entry_q[0];
  assign second = entry_q[1];
  assign third  = entry_q[2];
  assign depth  = DW'(spill_ptr_q) + DW'(resident_q);

  // NOTE: every always_comb output gets a default first so no path leaves a
  // latch behind.
  always_comb begin
    state_d     = state_q;
    start_spill = 1'b0;
    start_fill  = 1'b0;
    case (state_q)
      IDLE: begin
        // Transfers only start in a cycle the buffer is not being stepped.
        if (!accept) begin
          if (((resident_q >= RES_HIGH) || push_hz) && !ptr_full) begin
            start_spill = 1'b1;
            state_d     = SPILL;
          end else if (!ptr_empty && ((resident_q < RES_LOW) || pop_hz)) begin
            start_fill = 1'b1;
            state_d    = FILL;
          end
        end
      end
      SPILL, FILL: if (ack_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state below uses non-blocking assignments; the entry buffer is
  // a small register array read as top/second/third, so it is reset too.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LOCAL_DEPTH; i++) entry_q[i] <= '0;
      state_q      <= IDLE;
      resident_q   <= '0;
      spill_ptr_q  <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      err_overflow <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        case (movement)
          MV_HOLD: entry_q[0] <= next_top;
          MV_PUSH: begin
            for (int i = LOCAL_DEPTH - 1; i >= 1; i--) entry_q[i] <= entry_q[i-1];
            entry_q[0] <= next_top;
            // A full buffer is only accepted when memory is also full: the
            // shifted-out bottom entry is lost.
            if (resident_q == RES_FULL) err_overflow <= 1'b1;
            else                        resident_q   <= resident_q + RW'(1);
          end
          MV_POP1: begin
            for (int i = 1; i < LOCAL_DEPTH - 1; i++) entry_q[i] <= entry_q[i+1];
            entry_q[LOCAL_DEPTH-1] <= '0;
            entry_q[0]             <= next_top;
          end
          MV_POP2: begin
            for (int i = 1; i < LOCAL_DEPTH - 2; i++) entry_q[i] <= entry_q[i+2];
            entry_q[LOCAL_DEPTH-2] <= '0;
            entry_q[LOCAL_DEPTH-1] <= '0;
            entry_q[0]             <= next_top;
          end
          default: ;
        endcase
        if (is_pop) resident_q <= (resident_q > npops) ? resident_q - npops : '0;
      end

      if (start_spill) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= ADDR_WIDTH'(spill_ptr_q);
        mem_wdata <= entry_q[bot_idx];
      end
      if (start_fill) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= ADDR_WIDTH'(spill_ptr_q - PW'(1));
      end

      // Steps stall while a transfer is outstanding, so an ack never
      // coincides with an accepted step.
      if (ack_done) begin
        mem_req <= 1'b0;
        if (state_q == SPILL) begin
          entry_q[bot_idx] <= '0;
          resident_q       <= resident_q - RW'(1);
          spill_ptr_q      <= spill_ptr_q + PW'(1);
        end else if (state_q == FILL) begin
          entry_q[fill_idx] <= mem_rdata;
          resident_q        <= resident_q + RW'(1);
          spill_ptr_q       <= spill_ptr_q - PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dstack_spill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dstack_spill_ctrl
//
// Directed bench for dstack_spill_ctrl. Instance a uses default parameters,
// instance b uses ADDR_WIDTH = 2 to reach full memory depth. Steps are routed
// to one instance at a time by sel. Each instance has a backing-memory
// responder that acks after a programmable number of wait cycles and logs
// the transfers it serves.
// -----------------------------------------------------------------------------
module tb_dstack_spill_ctrl;

  localparam logic [1:0] HOLD = 2'b00, PUSH = 2'b01, POP1 = 2'b10, POP2 = 2'b11;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        step_valid = 1'b0;
  logic [1:0]  movement = HOLD;
  logic [31:0] next_top = '0;
  logic        sel = 1'b0;
  logic        sv_a, sv_b, stall_s;

  // instance a
  logic        stall_a, mem_req_a, mem_we_a, err_a;
  logic [31:0] top_a, second_a, third_a, mem_wdata_a;
  logic [14:0] depth_a;
  logic [9:0]  mem_addr_a;
  logic        mem_ack_a = 1'b0;
  logic [31:0] mem_rdata_a = '0;

  // instance b
  logic        stall_b, mem_req_b, mem_we_b, err_b;
  logic [31:0] top_b, second_b, third_b, mem_wdata_b;
  logic [6:0]  depth_b;
  logic [1:0]  mem_addr_b;
  logic        mem_ack_b = 1'b0;
  logic [31:0] mem_rdata_b = '0;

  int errors = 0;
  int checks = 0;
  int stall_cycles;
  bit stall_seen;

  always #5 clk = ~clk;

  assign sv_a    = step_valid && !sel;
  assign sv_b    = step_valid && sel;
  assign stall_s = sel ? stall_b : stall_a;

  dstack_spill_ctrl u_a (
    .clk(clk), .reset_n(reset_n), .step_valid(sv_a), .movement(movement),
    .next_top(next_top), .stall(stall_a), .top(top_a), .second(second_a),
    .third(third_a), .depth(depth_a), .mem_req(mem_req_a), .mem_we(mem_we_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_ack(mem_ack_a),
    .mem_rdata(mem_rdata_a), .err_overflow(err_a)
  );

  dstack_spill_ctrl #(.ADDR_WIDTH(2)) u_b (
    .clk(clk), .reset_n(reset_n), .step_valid(sv_b), .movement(movement),
    .next_top(next_top), .stall(stall_b), .top(top_b), .second(second_b),
    .third(third_b), .depth(depth_b), .mem_req(mem_req_b), .mem_we(mem_we_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_ack(mem_ack_b),
    .mem_rdata(mem_rdata_b), .err_overflow(err_b)
  );

  // ---------------- backing memory responders ----------------
  logic [31:0] mem_a [1024];
  int          ack_delay = 0;
  int          wait_a = 0;
  int          spill_cnt_a = 0, fill_cnt_a = 0;
  logic [9:0]  last_addr_a = '0;
  logic [31:0] last_wdata_a = '0;
  logic        last_we_a = 1'b0;

  always @(negedge clk) begin
    if (mem_req_a) begin
      if (wait_a == ack_delay) begin
        mem_ack_a   = 1'b1;
        wait_a      = 0;
        last_addr_a = mem_addr_a;
        last_we_a   = mem_we_a;
        if (mem_we_a) begin
          mem_a[mem_addr_a] = mem_wdata_a;
          last_wdata_a      = mem_wdata_a;
          spill_cnt_a++;
        end else begin
          mem_rdata_a = mem_a[mem_addr_a];
          fill_cnt_a++;
        end
      end else begin
        mem_ack_a = 1'b0;
        wait_a++;
      end
    end else begin
      mem_ack_a = 1'b0;
      wait_a    = 0;
    end
  end

  logic [31:0] mem_b [4];
  int          spill_cnt_b = 0, fill_cnt_b = 0;

  always @(negedge clk) begin
    if (mem_req_b && !mem_ack_b) begin
      mem_ack_b = 1'b1;
      if (mem_we_b) begin
        mem_b[mem_addr_b] = mem_wdata_b;
        spill_cnt_b++;
      end else begin
        mem_rdata_b = mem_b[mem_addr_b];
        fill_cnt_b++;
      end
    end else begin
      mem_ack_b = 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one step on the selected instance, hold it through any stall,
  // and return just after the accepting edge.
  task automatic do_step(input logic [1:0] mv, input logic [31:0] val);
    stall_cycles = 0;
    @(negedge clk);
    step_valid = 1'b1;
    movement   = mv;
    next_top   = val;
    #1;
    while (stall_s && stall_cycles < 50) begin
      stall_cycles++;
      @(negedge clk);
      #1;
    end
    if (stall_cycles >= 50) check("step_timeout", stall_s, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    step_valid = 1'b0;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    step_valid = 1'b0;
    reset_n    = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // reset after three pushes
    sel = 1'b0;
    do_step(PUSH, 32'd1);
    do_step(PUSH, 32'd2);
    do_step(PUSH, 32'd3);
    check("push3_top", top_a, 32'd3);
    check("push3_second", second_a, 32'd2);
    check("push3_third", third_a, 32'd1);
    check("push3_depth", depth_a, 15'd3);
    @(negedge clk);
    step_valid = 1'b0;
    reset_n    = 1'b0;
    #1;
    check("rst_top", top_a, 32'd0);
    check("rst_second", second_a, 32'd0);
    check("rst_third", third_a, 32'd0);
    check("rst_depth", depth_a, 15'd0);
    check("rst_mem_req", mem_req_a, 1'b0);
    check("rst_err", err_a, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_release_depth", depth_a, 15'd0);

    // hold, then pops down through saturation to an empty-stack pop
    do_step(PUSH, 32'h11);
    do_step(PUSH, 32'h22);
    do_step(PUSH, 32'h33);
    do_step(HOLD, 32'hA);
    check("hold_top", top_a, 32'hA);
    check("hold_second", second_a, 32'h22);
    check("hold_third", third_a, 32'h11);
    check("hold_depth", depth_a, 15'd3);
    do_step(POP2, 32'h44);
    check("pop2_top", top_a, 32'h44);
    check("pop2_second", second_a, 32'd0);
    check("pop2_depth", depth_a, 15'd1);
    do_step(POP2, 32'h55);
    check("pop2_sat_depth", depth_a, 15'd0);
    do_step(POP2, 32'd7);
    check("empty_pop_stall", stall_cycles, 0);
    check("empty_pop_top", top_a, 32'd7);
    check("empty_pop_depth", depth_a, 15'd0);
    idle(3);
    check("empty_pop_no_req", mem_req_a, 1'b0);
    check("empty_pop_no_xfer", spill_cnt_a + fill_cnt_a, 0);

    // spill with ack two cycles late
    reset_pulse();
    ack_delay = 2;
    for (int v = 1; v <= 8; v++) do_step(PUSH, 32'(v));
    check("spill_none_yet", spill_cnt_a, 0);
    do_step(PUSH, 32'd9);
    check("spill_stall_cycles", stall_cycles, 4);
    check("spill_cnt", spill_cnt_a, 1);
    check("spill_we", last_we_a, 1'b1);
    check("spill_addr", last_addr_a, 10'd0);
    check("spill_data", last_wdata_a, 32'd1);
    check("spill_top", top_a, 32'd9);
    check("spill_second", second_a, 32'd8);
    check("spill_depth", depth_a, 15'd9);
    // Idle drains down to HIGH_WATER-1 resident: two more spills.
    idle(20);
    check("drain_cnt", spill_cnt_a, 3);
    check("drain_mem1", mem_a[1], 32'd2);
    check("drain_mem2", mem_a[2], 32'd3);
    check("drain_depth", depth_a, 15'd9);
    check("drain_req_low", mem_req_a, 1'b0);

    // fill: spill_ptr 1 with mem[0]=5, resident 4, then pop2
    reset_pulse();
    ack_delay = 0;
    do_step(PUSH, 32'd5);
    for (int v = 2; v <= 8; v++) if (v != 5) do_step(PUSH, 32'(v));
    idle(6);
    check("fill_setup_mem0", mem_a[0], 32'd5);
    do_step(POP1, 32'd20);
    do_step(POP1, 32'd21);
    check("fill_setup_depth", depth_a, 15'd5);
    check("fill_setup_third", third_a, 32'd3);
    do_step(POP2, 32'd30);
    check("fill_stall_cycles", stall_cycles, 2);
    check("fill_cnt", fill_cnt_a, 1);
    check("fill_we", last_we_a, 1'b0);
    check("fill_addr", last_addr_a, 10'd0);
    check("fill_top", top_a, 32'd30);
    check("fill_second", second_a, 32'd2);
    check("fill_third", third_a, 32'd5);
    check("fill_depth", depth_a, 15'd3);

    // overflow on the 4-word memory instance
    reset_pulse();
    sel = 1'b1;
    stall_seen = 1'b0;
    for (int v = 1; v <= 12; v++) begin
      do_step(PUSH, 32'(v));
      if (stall_cycles != 0) stall_seen = 1'b1;
    end
    check("ovf_stalled", stall_seen, 1'b1);
    check("ovf_err_before", err_b, 1'b0);
    check("ovf_depth12", depth_b, 7'd12);
    do_step(PUSH, 32'd13);
    check("ovf_push13_stall", stall_cycles, 0);
    check("ovf_err", err_b, 1'b1);
    check("ovf_depth", depth_b, 7'd12);
    check("ovf_top", top_b, 32'd13);
    idle(10);
    check("ovf_spills", spill_cnt_b, 4);
    check("ovf_no_fill", fill_cnt_b, 0);
    check("ovf_mem0", mem_b[0], 32'd1);
    check("ovf_err_sticky", err_b, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
